// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier.
//   state_t : controller states (IDLE, ADD, DONE)
//   MUL_W   : datapath width, fixed to match the adder
package mul_pkg;

   localparam int MUL_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder.sv
// Combinational 16-bit unsigned adder; the carry out is dropped, so the sum
// wraps modulo 2^16.
//   in1, in2 : addends
//   out      : (in1 + in2) mod 2^16
module adder
   import mul_pkg::*;
(
   input  logic [MUL_W-1:0] in1,
   input  logic [MUL_W-1:0] in2,
   output logic [MUL_W-1:0] out
);

   assign out = in1 + in2;

endmodule

// File: rtl/repeated_add_mult.sv
// Sequential unsigned multiplier built from repeated addition around a
// single adder. The larger operand is added once per cycle, the smaller one
// sets the number of additions.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : request, accepted only while ready
//   a_in, b_in    : unsigned operands, sampled with an accepted start
//   ready         : controller idle
//   busy          : additions in progress
//   done          : one-cycle pulse, product valid
//   product       : accumulator ((a*b) mod 2^16 once done)
//   overflow      : sticky, some addition wrapped past 2^16
module repeated_add_mult
   import mul_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [MUL_W-1:0] a_in,
   input  logic [MUL_W-1:0] b_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [MUL_W-1:0] product,
   output logic             overflow
);

   state_t           state, state_nxt;
   logic [MUL_W-1:0] acc;
   logic [MUL_W-1:0] count;
   logic [MUL_W-1:0] addend;
   logic             ovf;
   logic [MUL_W-1:0] sum;
   logic [MUL_W-1:0] op_max, op_min;
   logic             accept;

   // An unsigned add wrapped exactly when the result is below an input.
   function automatic logic wrapped(input logic [MUL_W-1:0] s,
                                    input logic [MUL_W-1:0] x);
      return (s < x);
   endfunction

   adder u_adder (
      .in1 (acc),
      .in2 (addend),
      .out (sum)
   );

   // Iterating over the smaller operand keeps the run as short as possible.
   assign op_max = (a_in >= b_in) ? a_in : b_in;
   assign op_min = (a_in >= b_in) ? b_in : a_in;
   assign accept = (state == IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (op_min == '0) ? DONE : ADD;
            end
         end
         ADD: begin
            if (count == MUL_W'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         count  <= '0;
         addend <= '0;
         ovf    <= 1'b0;
      end else if (accept) begin
         acc    <= '0;
         count  <= op_min;
         addend <= op_max;
         ovf    <= 1'b0;
      end else if (state == ADD) begin
         acc    <= sum;
         count  <= count - MUL_W'(1);
         ovf    <= ovf | wrapped(sum, acc);
      end
   end

   assign ready    = (state == IDLE);
   assign busy     = (state == ADD);
   assign done     = (state == DONE);
   assign product  = acc;
   assign overflow = ovf;

endmodule

// File: tb/tb_repeated_add_mult.sv
module tb_repeated_add_mult;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic        overflow;

   typedef struct {
      logic [15:0] p;
      logic        ov;
      int          n;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   repeated_add_mult dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .product  (product),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"},    32'(ready),    32'd1);
      chk({tag, "_busy"},     32'(busy),     32'd0);
      chk({tag, "_done"},     32'(done),     32'd0);
      chk({tag, "_product"},  32'(product),  32'd0);
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
   endtask

   // Drive one operation and check it against the scoreboard. With inject
   // set, a second start (9x9) is pulsed while the first is still adding.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input bit inject);
      exp_t        e;
      logic [31:0] full;
      int          idx;
      int          busy_cnt;
      bit          seen;
      @(negedge clk);
      chk({tag, "_ready_in"}, 32'(ready), 32'd1);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      full  = 32'(a) * 32'(b);
      e.p   = full[15:0];
      e.ov  = (full > 32'd65535);
      e.n   = (a < b) ? int'(a) : int'(b);
      sb.push_back(e);
      @(negedge clk);
      start    = 1'b0;
      idx      = 1;
      busy_cnt = 0;
      seen     = 1'b0;
      while (!seen && idx < 70000) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) busy_cnt++;
            if (inject && idx == 2) begin
               start = 1'b1;
               a_in  = 16'd9;
               b_in  = 16'd9;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            idx++;
         end
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      e = sb.pop_front();
      chk({tag, "_product"},  32'(product),  32'(e.p));
      chk({tag, "_overflow"}, 32'(overflow), 32'(e.ov));
      chk({tag, "_done_cyc"}, 32'(idx),      32'(e.n + 1));
      chk({tag, "_busy_cyc"}, 32'(busy_cnt), 32'(e.n));
      @(negedge clk);
      chk({tag, "_ready_out"},   32'(ready),   32'd1);
      chk({tag, "_done_pulse"},  32'(done),    32'd0);
      chk({tag, "_product_hold"}, 32'(product), 32'(e.p));
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_outputs("post_reset");

      run_op("basic_5x3",    16'd5,    16'd3,    1'b0);
      run_op("swap_3x1000",  16'd3,    16'd1000, 1'b0);
      run_op("swap_1000x3",  16'd1000, 16'd3,    1'b0);
      run_op("zero_7x0",     16'd7,    16'd0,    1'b0);
      run_op("zero_0x9",     16'd0,    16'd9,    1'b0);
      run_op("ovf_300x300",  16'd300,  16'd300,  1'b0);
      run_op("after_ovf_2x2", 16'd2,   16'd2,    1'b0);
      run_op("busy_start_4x6", 16'd4,  16'd6,    1'b1);

      // Reset in the middle of a 10x10 run, two additions in.
      @(negedge clk);
      start = 1'b1;
      a_in  = 16'd10;
      b_in  = 16'd10;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_partial_sum", 32'(product), 32'd20);
      chk("mid_busy",        32'(busy),    32'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_reset_2x4", 16'd2, 16'd4, 1'b0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/repeated_add_mult.md
# repeated_add_mult

Sequential unsigned multiplier that forms a product by repeated addition. It is the control and accumulator stage wrapped around the existing 16-bit `adder` datapath element. It latches two operands on a start handshake and feeds the adder one addend per cycle. Each cycle it registers the adder's sum back into the accumulator, then reports the truncated 16-bit product with a one-cycle done pulse and a sticky overflow flag.

## Interface
- Parameters: none. Data width is fixed at 16 bits to match `adder`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request; sampled only while `ready`=1.
- `a_in` input 16: multiplicand, unsigned; sampled with `start`.
- `b_in` input 16: multiplier, unsigned; sampled with `start`.
- `ready` output 1: high only in IDLE.
- `busy` output 1: high in ADD.
- `done` output 1: one-cycle pulse, high in DONE.
- `product` output 16: accumulator value, equal to (a×b) mod 2^16 once done.
- `overflow` output 1: sticky; set if any addition wrapped past 2^16.

## Operation
- States are IDLE, ADD and DONE. All outputs are Moore decodes of state or registers.
- IDLE with `start`=1:
  - Load `addend` = max(a_in, b_in) and `count` = min(a_in, b_in). The smaller operand sets the iteration count.
  - Clear `acc` and `overflow`.
  - Go to DONE if `count`=0, otherwise go to ADD.
- IDLE with `start`=0: hold. `product` keeps the last result.
- ADD, each edge:
  - `acc` ← adder.out, where adder.in1 = `acc` and adder.in2 = `addend`.
  - `count` ← `count`−1.
  - `overflow` ← `overflow` | (adder.out < `acc`), as an unsigned compare.
  - When `count`=1 before the edge, go to DONE.
- DONE: go to IDLE unconditionally on the next edge.
- `start` in ADD or DONE is ignored. Operands are not re-sampled until the next IDLE.
- Arithmetic is unsigned, modulo 2^16. No saturation.
- `product` = `acc`. It shows partial sums while `busy`. It is valid and stable from the `done` cycle until the next accepted `start`.

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `product`=0, `overflow`=0, `count`=0, `addend`=0.
- Let `start` be accepted at edge k and N = min(a_in, b_in). `done` is high in the cycle after edge k+N, for exactly one cycle. For N=0 this is the cycle after edge k.
- `ready` returns high in the cycle after edge k+N+1. A new `start` can therefore be accepted N+2 edges after the previous one.
- Worst case N = 65535 gives 65537 cycles start-to-ready.
- Adder path is combinational. Sum-to-`acc` is a single-cycle path.
- Reset asserted mid-operation returns every output to its reset value immediately, independent of `clk`. The partial result is discarded.
- If `start` is held high continuously, a new operation is accepted on each IDLE cycle.

## Structure
- Shared package `mul_pkg`:
  - `state_t` enum {IDLE, ADD, DONE}.
  - `localparam MUL_W = 16`.
- Sub-module: one instance of the existing `adder` (in1 = `acc`, in2 = `addend`).
- Everything else stays local to the block:
  - the state register
  - the `acc`, `count` and `addend` registers
  - the min/max operand comparator
  - the overflow compare

## Test plan
- Basic multiply: a=5, b=3, start at edge k → `busy` for 3 cycles, `done` after edge k+3, `product`=15, `overflow`=0, `ready` after edge k+4.
- Operand swap: a=3, b=1000 → exactly 3 ADD cycles, `product`=3000, `overflow`=0. Repeat with a=1000, b=3 and require the same result and timing.
- Zero operand: a=7, b=0 → `done` in the cycle after edge k, `product`=0, `busy` never high. Repeat with a=0, b=9 and require the same.
- Overflow: a=300, b=300 → 300 ADD cycles, `product`=24464 (90000 mod 65536), `overflow`=1. The following run with a=2, b=2 gives `product`=4 and `overflow`=0.
- Start while busy: start a=4, b=6, then pulse `start` with a=9, b=9 during ADD → ignored; `product`=24 and the timing is unchanged.
- Reset mid-operation: start a=10, b=10, drop `rst_n` after 2 adds → all outputs at reset values immediately. After release, start a=2, b=4 → `product`=8 with normal timing.
